// File: rtl/pixel_stream_unpacker.sv
// pixel_stream_unpacker
// Rebuilds 12-bit RGB pixels from a two-byte-per-pixel stream
// (byte 0 = {4'b0, R}, byte 1 = {G, B}), buffers them in a small FIFO and
// replays them onto the rgb bus, one per pixel_tick while video_on is high.
//
// Ports:
//   clk          system clock, rising edge
//   reset        asynchronous active-high reset
//   byte_in      stream byte
//   byte_valid   byte_in valid this cycle
//   byte_ready   byte accepted this cycle when valid (combinational)
//   pixel_tick   pixel-rate enable
//   video_on     active display area, qualified by pixel_tick
//   clear_flags  synchronous clear of the sticky flags
//   rgb          registered output pixel {R,G,B}
//   level        FIFO occupancy 0..DEPTH
//   underflow    sticky: pixel needed while FIFO empty
//   hdr_err      sticky: first byte had a nonzero upper nibble
module pixel_stream_unpacker #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [7:0]    byte_in,
  input  logic          byte_valid,
  output logic          byte_ready,
  input  logic          pixel_tick,
  input  logic          video_on,
  input  logic          clear_flags,
  output logic [11:0]   rgb,
  output logic [AW:0]   level,
  output logic          underflow,
  output logic          hdr_err
);

  typedef enum logic {
    PH_RED = 1'b0,
    PH_GB  = 1'b1
  } phase_t;

  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE  = (AW+1)'(1);

  phase_t        phase;
  logic [3:0]    r_nib;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [11:0]   mem [DEPTH];

  logic accept;
  logic push;
  logic pop;
  logic want_pixel;
  logic underflow_set;
  logic hdr_set;

  // The slot for a pixel is reserved when its first byte is taken; level
  // can only fall before the second byte arrives, so phase 1 never stalls.
  always_comb begin
    byte_ready = (phase == PH_GB) ? 1'b1 : (level < FULL);
  end

  always_comb begin
    accept        = byte_valid && byte_ready;
    push          = accept && (phase == PH_GB);
    want_pixel    = pixel_tick && video_on;
    pop           = want_pixel && (level != '0);
    underflow_set = want_pixel && (level == '0);
    hdr_set       = accept && (phase == PH_RED) && (byte_in[7:4] != 4'h0);
  end

  // Storage has no reset; validity is tracked entirely by the pointers.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {r_nib, byte_in};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase     <= PH_RED;
      r_nib     <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      rgb       <= '0;
      underflow <= 1'b0;
      hdr_err   <= 1'b0;
    end else begin
      // byte assembly
      if (accept) begin
        case (phase)
          PH_RED: begin
            if (byte_in[7:4] == 4'h0) begin
              r_nib <= byte_in[3:0];
              phase <= PH_GB;
            end
          end
          PH_GB: begin
            wr_ptr <= wr_ptr + AW'(1);
            phase  <= PH_RED;
          end
          default: phase <= PH_RED;
        endcase
      end

      // pixel output; pop sees only entries written in earlier cycles
      if (pixel_tick) begin
        if (pop) begin
          rgb    <= mem[rd_ptr];
          rd_ptr <= rd_ptr + AW'(1);
        end else begin
          rgb <= '0;
        end
      end

      if (push && !pop) begin
        level <= level + ONE;
      end else if (pop && !push) begin
        level <= level - ONE;
      end

      // sticky flags: a set in the same cycle as a clear wins
      if (underflow_set) begin
        underflow <= 1'b1;
      end else if (clear_flags) begin
        underflow <= 1'b0;
      end

      if (hdr_set) begin
        hdr_err <= 1'b1;
      end else if (clear_flags) begin
        hdr_err <= 1'b0;
      end
    end
  end

endmodule
